// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the 32-bit iterative divider behind MIPS DIV/DIVU.
// Latches the operands on a level-held request and runs a 32-step radix-2
// restoring divide on the operand magnitudes. It then sign-corrects the
// quotient and remainder and presents {remainder, quotient} on `result`.
// `stall_req` holds the pipeline until `ready` is high.
//
// Optional feature (macro DIV_ZERO_FAST_EN): a zero divisor seen in IDLE
// takes a short path through DZERO and returns result = 0 after one
// busy cycle. Without the macro, a zero divisor runs the full algorithm.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   start      in   divide request, held high until ready
//   signed_div in   1 = DIV (two's complement), 0 = DIVU; sampled in IDLE
//   opdata1    in   [31:0] dividend, sampled in IDLE
//   opdata2    in   [31:0] divisor, sampled in IDLE
//   annul      in   flush/kill; returns to IDLE on the next edge
//   result     out  [63:0] {remainder (HI), quotient (LO)}, registered
//   ready      out  result valid, registered
//   busy       out  high in ON / DZERO
//   stall_req  out  start & ~ready & ~annul (combinational)
//   dbg_state  out  [1:0] current FSM state, for observation
//
// Handshake: the requester raises `start` and holds it until it sees
// `ready`. The result stays valid in DONE for as long as `start` stays
// high. Dropping `start` releases the unit, which returns to IDLE.
// `annul` overrides everything and never produces a result.

module div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy,
    output logic        stall_req,
    output logic [1:0]  dbg_state
);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_DZERO = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next;

    logic        r_signed;
    logic        r_sign1;
    logic        r_sign2;
    logic [31:0] r_rem;      // partial remainder
    logic [31:0] r_quo;      // dividend shifting out / quotient shifting in
    logic [31:0] r_dvs;      // divisor magnitude
    logic [5:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_upper;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_last;
    logic        w_accept;

    // Magnitudes only for DIV; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    assign w_mag1 = (signed_div & opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    assign w_mag2 = (signed_div & opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

    // Upper 33 bits of {rem, dividend} << 1. The remainder is always below
    // the divisor, so when the trial subtraction succeeds the true
    // difference fits in 32 bits and a 32-bit subtract is exact.
    assign w_upper  = {r_rem, r_quo[31]};
    assign w_ge     = (w_upper >= {1'b0, r_dvs});
    assign w_sub    = w_upper[31:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_sub : w_upper[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};

    assign w_quo_fix = (r_signed & (r_sign1 ^ r_sign2)) ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_rem_fix = (r_signed & r_sign1) ? (~w_rem_nx + 32'd1) : w_rem_nx;

    assign w_last   = (r_cnt == 6'd31);
    assign w_accept = start & ~annul;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                    w_next = (opdata2 == 32'd0) ? S_DZERO : S_ON;
`else
                    w_next = S_ON;
`endif
                end
            end
            S_ON: begin
                if (w_last) w_next = S_DONE;
            end
`ifdef DIV_ZERO_FAST_EN
            S_DZERO: w_next = S_DONE;
`endif
            S_DONE: begin
                if (!start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (annul) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_signed <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else if (annul) begin
            // Kill wins over everything, including the final iteration.
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_signed <= signed_div;
                        r_sign1  <= opdata1[31];
                        r_sign2  <= opdata2[31];
                        r_rem    <= 32'd0;
                        r_quo    <= w_mag1;
                        r_dvs    <= w_mag2;
                        r_cnt    <= 6'd0;
                    end
                end
                S_ON: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                S_DZERO: begin
                    r_result <= 64'd0;
                    r_ready  <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (!start) r_ready <= 1'b0;
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

`ifdef DIV_ZERO_FAST_EN
    assign busy = (r_state == S_ON) | (r_state == S_DZERO);
`else
    assign busy = (r_state == S_ON);
`endif

    assign result    = r_result;
    assign ready     = r_ready;
    assign stall_req = start & ~r_ready & ~annul;
    assign dbg_state = r_state;

endmodule
